// File: rtl/dcache_evict_buf.sv
// Write-back buffer between the L1 data cache and the memory request bus.
// Evicted dirty lines are queued in a small circular FIFO and drained one at
// a time; queued line addresses can be probed so the cache can stall a miss
// that targets a line still waiting to be written.
module dcache_evict_buf #(
    parameter int abus   = 48,
    parameter int lnbits = 5,
    parameter int depth  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic                      i_wb_valid,
    output logic                      o_wb_ready,
    input  logic [abus-1:0]           i_wb_addr,
    input  logic [8*(2**lnbits)-1:0]  i_wb_data,
    input  logic [(2**lnbits)-1:0]    i_wb_strb,
    input  logic [abus-1:0]           i_chk_addr,
    output logic                      o_chk_hit,
    output logic                      o_mem_req_valid,
    input  logic                      i_mem_req_ready,
    output logic [abus-1:0]           o_mem_req_addr,
    output logic [8*(2**lnbits)-1:0]  o_mem_req_data,
    output logic [(2**lnbits)-1:0]    o_mem_req_strb,
    input  logic                      i_mem_resp_valid,
    input  logic                      i_mem_resp_err,
    output logic                      o_mem_resp_ready,
    output logic                      o_empty,
    output logic                      o_err_valid,
    output logic [abus-1:0]           o_err_addr
);

    localparam int LW = 8 * (2 ** lnbits);
    localparam int SW = 2 ** lnbits;
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [depth-1:0] valid_q, valid_d;
    logic             err_valid_q, err_valid_d;
    logic [abus-1:0]  err_addr_q, err_addr_d;

    logic [abus-1:0]  ent_addr_q [depth];
    logic [abus-1:0]  ent_addr_d [depth];
    logic [LW-1:0]    ent_data_q [depth];
    logic [LW-1:0]    ent_data_d [depth];
    logic [SW-1:0]    ent_strb_q [depth];
    logic [SW-1:0]    ent_strb_d [depth];

    logic             wb_ready;
    logic             push;
    logic             pop;
    logic             req_active;
    logic [abus-1:0]  head_addr;

    // Handshake qualifiers; ready depends on registered count only, so a
    // push is never accepted on the strength of a same-cycle pop.
    always_comb begin
        wb_ready   = (count_q != CW'(depth));
        push       = i_wb_valid & wb_ready;
        pop        = (state_q == ST_WAIT) & i_mem_resp_valid;
        req_active = (state_q == ST_REQ) | (state_q == ST_WAIT);
        head_addr  = {ent_addr_q[rd_ptr_q][abus-1:lnbits], {lnbits{1'b0}}};
    end

    // Drain FSM: one outstanding write, head popped on its response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (count_q != '0) state_d = ST_REQ;
            ST_REQ:  if (i_mem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (i_mem_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers, occupancy, per-entry valid bits and error capture.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        valid_d     = valid_q;
        err_valid_d = 1'b0;
        err_addr_d  = err_addr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (!push && pop) count_d = count_q - CW'(1);
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
        if (pop && i_mem_resp_err) begin
            err_valid_d = 1'b1;
            err_addr_d  = head_addr;
        end
    end

    // Entry storage written at the tail on push.
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_strb_d = ent_strb_q;
        if (push) begin
            ent_addr_d[wr_ptr_q] = i_wb_addr;
            ent_data_d[wr_ptr_q] = i_wb_data;
            ent_strb_d[wr_ptr_q] = i_wb_strb;
        end
    end

    // Line-address probe over registered valid entries only.
    always_comb begin
        o_chk_hit = 1'b0;
        for (int unsigned i = 0; i < depth; i++) begin
            if (valid_q[i] && (ent_addr_q[i][abus-1:lnbits] == i_chk_addr[abus-1:lnbits]))
                o_chk_hit = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Entry payload registers; contents are qualified by valid_q, so no reset.
    always_ff @(posedge i_clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_strb_q <= ent_strb_d;
    end

    // Output mapping; request fields are forced to zero outside Req/WaitResp.
    always_comb begin
        o_wb_ready       = wb_ready;
        o_mem_req_valid  = (state_q == ST_REQ);
        o_mem_req_addr   = req_active ? head_addr : '0;
        o_mem_req_data   = req_active ? ent_data_q[rd_ptr_q] : '0;
        o_mem_req_strb   = req_active ? ent_strb_q[rd_ptr_q] : '0;
        o_mem_resp_ready = (state_q == ST_WAIT);
        o_empty          = (count_q == '0) && (state_q == ST_IDLE);
        o_err_valid      = err_valid_q;
        o_err_addr       = err_addr_q;
    end

endmodule
